dual_issue_queue: RTL and testbench

- Parametrised instruction queue between IF and ID for the next-generation dual-issue MIPS pipeline.
- Replaces the fixed rule "word 0 is ALU/branch, word 1 is LW/SW" with dynamic steering:
  - buffers fetched instruction pairs;
  - sends each instruction in order to the ALU slot (s0) or the memory slot (s1);
  - pairs two instructions only when they do not conflict.
- Decouples fetch from decode stalls. Branch redirect is handled by flush.

---
 rtl/dual_issue_queue_if.sv | 29 ++
 rtl/dual_issue_queue.sv | 148 ++++++++++++++
 tb/tb_dual_issue_queue.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_issue_queue_if.sv
// Fetch-side pair handshake and issue-side dual-slot bus for the dual-issue queue.
// The queue connects through the slave modport; fetch/decode (or a bench) use master.
interface dual_issue_queue_if #(
   parameter int PC_W = 32
);
   logic            in_valid;
   logic [31:0]     in_inst0;
   logic [31:0]     in_inst1;
   logic [PC_W-1:0] in_pc;
   logic            in_ready;

   logic            issue_ready;
   logic            s0_valid;
   logic [31:0]     s0_inst;
   logic [PC_W-1:0] s0_pc;
   logic            s1_valid;
   logic [31:0]     s1_inst;
   logic [PC_W-1:0] s1_pc;

   modport master (
      output in_valid, in_inst0, in_inst1, in_pc, issue_ready,
      input  in_ready, s0_valid, s0_inst, s0_pc, s1_valid, s1_inst, s1_pc
   );

   modport slave (
      input  in_valid, in_inst0, in_inst1, in_pc, issue_ready,
      output in_ready, s0_valid, s0_inst, s0_pc, s1_valid, s1_inst, s1_pc
   );
endinterface

// File: rtl/dual_issue_queue.sv
// Instruction queue between IF and ID: buffers fetched pairs and steers them in order
// into the ALU slot (s0) and memory slot (s1), co-issuing two only when they cannot conflict.
module dual_issue_queue #(
   parameter int DEPTH = 8,
   parameter int PC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   dual_issue_queue_if.slave        bus,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      CLS_ALU,
      CLS_MEM,
      CLS_BR
   } cls_t;

   typedef struct packed {
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   head_reg, tail_reg;
   logic [AW-1:0]   head_next, tail_next;
   logic [CW-1:0]   count_reg, count_next;

   logic            push;
   logic [1:0]      pop_cnt;
   logic            head_valid;
   logic            h_mem, h_br, n_mem;
   logic            raw_hit, waw_hit, pair_ok;
   logic [4:0]      n_rs, n_rt;
   logic            n_rs_rd, n_rt_rd;
   entry_t          s0_ent, s1_ent;

   // Decode class and destination of the head (gi=0) and the entry behind it (gi=1).
   for (genvar gi = 0; gi < 2; gi++) begin : gen_dec
      entry_t     ent;
      cls_t       cls;
      logic [4:0] wreg;
      logic       wr;

      always_comb begin
         ent  = mem[(gi == 0) ? head_reg : head_reg + AW'(1)];
         cls  = CLS_ALU;
         wreg = 5'd0;
         case (ent.inst[31:26])
            6'h00:        wreg = ent.inst[15:11];
            6'h08:        wreg = ent.inst[20:16];
            6'h23: begin
               cls  = CLS_MEM;
               wreg = ent.inst[20:16];
            end
            6'h2B:        cls  = CLS_MEM;
            6'h04, 6'h05: cls  = CLS_BR;
            default:      ;
         endcase
         wr = (wreg != 5'd0);
      end
   end

   // Only the second entry's sources matter: it is the one that could read H's result.
   always_comb begin
      n_rs    = gen_dec[1].ent.inst[25:21];
      n_rt    = gen_dec[1].ent.inst[20:16];
      n_rs_rd = 1'b0;
      n_rt_rd = 1'b0;
      case (gen_dec[1].ent.inst[31:26])
         6'h00, 6'h04, 6'h05, 6'h2B: begin
            n_rs_rd = 1'b1;
            n_rt_rd = 1'b1;
         end
         6'h08, 6'h23: n_rs_rd = 1'b1;
         default:      ;
      endcase
   end

   always_comb begin
      head_valid = (count_reg != '0);
      h_mem      = (gen_dec[0].cls == CLS_MEM);
      h_br       = (gen_dec[0].cls == CLS_BR);
      n_mem      = (gen_dec[1].cls == CLS_MEM);
      raw_hit    = gen_dec[0].wr &&
                   ((n_rs_rd && (n_rs == gen_dec[0].wreg)) ||
                    (n_rt_rd && (n_rt == gen_dec[0].wreg)));
      waw_hit    = gen_dec[0].wr && gen_dec[1].wr &&
                   (gen_dec[0].wreg == gen_dec[1].wreg);
      pair_ok    = (count_reg >= CW'(2)) && !h_br && (h_mem != n_mem) &&
                   !raw_hit && !waw_hit;
   end

   always_comb begin
      s0_ent       = h_mem ? gen_dec[1].ent : gen_dec[0].ent;
      s1_ent       = h_mem ? gen_dec[0].ent : gen_dec[1].ent;
      bus.s0_valid = head_valid && (!h_mem || pair_ok);
      bus.s1_valid = head_valid && (h_mem || pair_ok);
      bus.s0_inst  = bus.s0_valid ? s0_ent.inst : '0;
      bus.s0_pc    = bus.s0_valid ? s0_ent.pc   : '0;
      bus.s1_inst  = bus.s1_valid ? s1_ent.inst : '0;
      bus.s1_pc    = bus.s1_valid ? s1_ent.pc   : '0;
   end

   // Acceptance looks only at the registered occupancy, never at this cycle's pop.
   assign bus.in_ready = (count_reg <= CW'(DEPTH - 2));
   assign push         = bus.in_valid && bus.in_ready;
   assign count        = count_reg;

   always_comb begin
      pop_cnt = 2'd0;
      if (bus.issue_ready && head_valid) begin
         pop_cnt = pair_ok ? 2'd2 : 2'd1;
      end
      head_next  = head_reg + AW'(pop_cnt);
      tail_next  = push ? tail_reg + AW'(2) : tail_reg;
      count_next = count_reg + (push ? CW'(2) : CW'(0)) - CW'(pop_cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Storage has no reset; entries are only observed while counted as occupied.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[tail_reg]          <= '{inst: bus.in_inst0, pc: bus.in_pc};
         mem[tail_reg + AW'(1)] <= '{inst: bus.in_inst1, pc: bus.in_pc + PC_W'(4)};
      end
   end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue: directed scenarios plus random traffic, checked each cycle
// against a queue-based reference model that applies the steering rules with register masks.
module tb_dual_issue_queue;

   localparam int DEPTH = 8;
   localparam int PC_W  = 32;

   localparam logic [31:0] I_ADD  = 32'h00221820;
   localparam logic [31:0] I_LW4  = 32'h8CA40000;
   localparam logic [31:0] I_LW3  = 32'h8CA30000;
   localparam logic [31:0] I_ADDI = 32'h20660001;
   localparam logic [31:0] I_BEQ  = 32'h10220001;

   logic                    clk;
   logic                    rst_n;
   logic                    flush;
   logic [$clog2(DEPTH):0]  count;

   dual_issue_queue_if #(.PC_W(PC_W)) bus ();

   dual_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: registers written / read expressed as 32-bit masks.
   function automatic logic [31:0] wr_mask(input logic [31:0] i);
      logic [31:0] m;
      case (i[31:26])
         6'h00:        m = 32'b1 << i[15:11];
         6'h08, 6'h23: m = 32'b1 << i[20:16];
         default:      m = 32'b0;
      endcase
      return m & ~32'b1;
   endfunction

   function automatic logic [31:0] rd_mask(input logic [31:0] i);
      case (i[31:26])
         6'h00, 6'h04, 6'h05, 6'h2B: return (32'b1 << i[25:21]) | (32'b1 << i[20:16]);
         6'h08, 6'h23:               return 32'b1 << i[25:21];
         default:                    return 32'b0;
      endcase
   endfunction

   function automatic bit goes_mem(input logic [31:0] i);
      return (i[31:26] == 6'h23) || (i[31:26] == 6'h2B);
   endfunction

   function automatic bit is_branch(input logic [31:0] i);
      return (i[31:26] == 6'h04) || (i[31:26] == 6'h05);
   endfunction

   function automatic int model_issue();
      if (q.size() == 0) return 0;
      if (q.size() < 2) return 1;
      if (is_branch(q[0].inst)) return 1;
      if (goes_mem(q[0].inst) == goes_mem(q[1].inst)) return 1;
      if ((rd_mask(q[1].inst) & wr_mask(q[0].inst)) != 0) return 1;
      if ((wr_mask(q[1].inst) & wr_mask(q[0].inst)) != 0) return 1;
      return 2;
   endfunction

   task automatic check_outputs();
      int          n;
      logic        e0v, e1v;
      logic [31:0] e0i, e0p, e1i, e1p;
      n   = model_issue();
      e0v = 0; e1v = 0; e0i = 0; e0p = 0; e1i = 0; e1p = 0;
      if (n > 0) begin
         if (goes_mem(q[0].inst)) begin
            e1v = 1; e1i = q[0].inst; e1p = q[0].pc;
            if (n == 2) begin e0v = 1; e0i = q[1].inst; e0p = q[1].pc; end
         end else begin
            e0v = 1; e0i = q[0].inst; e0p = q[0].pc;
            if (n == 2) begin e1v = 1; e1i = q[1].inst; e1p = q[1].pc; end
         end
      end
      chk("count",    64'(count),        64'(q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() <= DEPTH - 2));
      chk("s0_valid", 64'(bus.s0_valid), 64'(e0v));
      chk("s0_inst",  64'(bus.s0_inst),  64'(e0i));
      chk("s0_pc",    64'(bus.s0_pc),    64'(e0p));
      chk("s1_valid", 64'(bus.s1_valid), 64'(e1v));
      chk("s1_inst",  64'(bus.s1_inst),  64'(e1i));
      chk("s1_pc",    64'(bus.s1_pc),    64'(e1p));
   endtask

   task automatic model_update(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] pc, input logic ir, input logic fl);
      int n;
      bit room;
      if (fl) begin
         q.delete();
         $display("flush: queue cleared");
      end else begin
         n    = ir ? model_issue() : 0;
         room = (q.size() <= DEPTH - 2);
         for (int k = 0; k < n; k++) begin
            $display("issue pc=%08h inst=%08h", q[0].pc, q[0].inst);
            void'(q.pop_front());
         end
         if (v && room) begin
            q.push_back('{inst: i0, pc: pc});
            q.push_back('{inst: i1, pc: pc + 32'd4});
            $display("push  pc=%08h inst0=%08h inst1=%08h", pc, i0, i1);
         end
      end
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic cycle(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc, input logic ir, input logic fl);
      bus.in_valid    = v;
      bus.in_inst0    = i0;
      bus.in_inst1    = i1;
      bus.in_pc       = pc;
      bus.issue_ready = ir;
      flush           = fl;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update(v, i0, i1, pc, ir, fl);
      #1;
   endtask

   task automatic idle(input logic ir);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, ir, 1'b0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [5:0] op;
      case ($urandom_range(0, 7))
         0:       op = 6'h00;
         1:       op = 6'h08;
         2:       op = 6'h23;
         3:       op = 6'h2B;
         4:       op = 6'h04;
         5:       op = 6'h05;
         6:       op = 6'h0F;
         default: op = 6'($urandom);
      endcase
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
   endfunction

   initial begin
      rst_n           = 1'b0;
      flush           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_inst0    = '0;
      bus.in_inst1    = '0;
      bus.in_pc       = '0;
      bus.issue_ready = 1'b0;
      #2;
      chk("rst_count",    64'(count),        64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_s0_valid", 64'(bus.s0_valid), 64'd0);
      chk("rst_s1_valid", 64'(bus.s1_valid), 64'd0);
      chk("rst_s0_inst",  64'(bus.s0_inst),  64'd0);
      chk("rst_s1_pc",    64'(bus.s1_pc),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Independent ALU + LW pair co-issues.
      cycle(1'b1, I_ADD, I_LW4, 32'h0, 1'b1, 1'b0);
      chk("pair_s0_valid", 64'(bus.s0_valid), 64'd1);
      chk("pair_s0_inst",  64'(bus.s0_inst),  64'(I_ADD));
      chk("pair_s0_pc",    64'(bus.s0_pc),    64'h0);
      chk("pair_s1_valid", 64'(bus.s1_valid), 64'd1);
      chk("pair_s1_inst",  64'(bus.s1_inst),  64'(I_LW4));
      chk("pair_s1_pc",    64'(bus.s1_pc),    64'h4);
      idle(1'b1);
      chk("pair_count", 64'(count), 64'd0);

      // RAW dependence splits the pair.
      cycle(1'b1, I_LW3, I_ADDI, 32'h8, 1'b0, 1'b0);
      chk("raw_s1_valid", 64'(bus.s1_valid), 64'd1);
      chk("raw_s1_inst",  64'(bus.s1_inst),  64'(I_LW3));
      chk("raw_s1_pc",    64'(bus.s1_pc),    64'h8);
      chk("raw_s0_valid", 64'(bus.s0_valid), 64'd0);
      idle(1'b1);
      chk("raw2_s0_valid", 64'(bus.s0_valid), 64'd1);
      chk("raw2_s0_inst",  64'(bus.s0_inst),  64'(I_ADDI));
      chk("raw2_s0_pc",    64'(bus.s0_pc),    64'hC);
      chk("raw2_s1_valid", 64'(bus.s1_valid), 64'd0);
      idle(1'b1);
      chk("raw_count", 64'(count), 64'd0);

      // Branch issues alone.
      cycle(1'b1, I_BEQ, I_LW4, 32'h10, 1'b0, 1'b0);
      chk("br_s0_inst",  64'(bus.s0_inst),  64'(I_BEQ));
      chk("br_s1_valid", 64'(bus.s1_valid), 64'd0);
      idle(1'b1);
      chk("br2_s1_inst",  64'(bus.s1_inst),  64'(I_LW4));
      chk("br2_s1_pc",    64'(bus.s1_pc),    64'h14);
      chk("br2_s0_valid", 64'(bus.s0_valid), 64'd0);
      idle(1'b1);

      // Two ALU ops need the same slot.
      cycle(1'b1, I_ADD, I_ADD, 32'h20, 1'b0, 1'b0);
      chk("alu_s0_pc",    64'(bus.s0_pc),    64'h20);
      chk("alu_s1_valid", 64'(bus.s1_valid), 64'd0);
      idle(1'b1);
      chk("alu2_s0_pc", 64'(bus.s0_pc), 64'h24);
      idle(1'b1);
      chk("alu_count", 64'(count), 64'd0);

      // Fill to full, reject a fifth pair, drain, push again across the wrap.
      for (int k = 0; k < 4; k++) cycle(1'b1, rand_inst(), rand_inst(), 32'h100 + 32'(8 * k), 1'b0, 1'b0);
      chk("full_count",    64'(count),        64'd8);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      cycle(1'b1, I_ADD, I_ADD, 32'h900, 1'b0, 1'b0);
      chk("full_ignored", 64'(count), 64'd8);
      for (int k = 0; k < 20 && q.size() != 0; k++) idle(1'b1);
      chk("drain_empty", 64'(q.size()), 64'd0);
      cycle(1'b1, I_ADD, I_LW4, 32'h200, 1'b0, 1'b0);
      cycle(1'b1, I_LW3, I_ADDI, 32'h208, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) idle(1'b1);

      // Flush overrides push and pop in the same cycle.
      cycle(1'b1, I_ADD, I_LW4, 32'h300, 1'b0, 1'b0);
      cycle(1'b1, I_BEQ, I_ADD, 32'h308, 1'b0, 1'b0);
      chk("flush_pre_count", 64'(count), 64'd4);
      cycle(1'b1, I_ADD, I_LW4, 32'h310, 1'b1, 1'b1);
      chk("flush_count",    64'(count),        64'd0);
      chk("flush_s0_valid", 64'(bus.s0_valid), 64'd0);
      chk("flush_s1_valid", 64'(bus.s1_valid), 64'd0);
      idle(1'b0);
      chk("flush_discard", 64'(count), 64'd0);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 9) < 7), rand_inst(), rand_inst(),
               32'($urandom) & 32'hFFFF_FFFC, ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 49) == 0));
      end

      // Asynchronous reset in the middle of operation with five entries held.
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) cycle(1'b1, I_BEQ, I_ADD, 32'h400 + 32'(8 * k), 1'b0, 1'b0);
      idle(1'b1);
      chk("mid_count", 64'(count), 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count",    64'(count),        64'd0);
      chk("arst_s0_valid", 64'(bus.s0_valid), 64'd0);
      chk("arst_s1_valid", 64'(bus.s1_valid), 64'd0);
      chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("arst_s0_inst",  64'(bus.s0_inst),  64'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, I_ADD, I_LW4, 32'h500, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
